instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction-fetch stage plus IF/ID register; sits directly upstream of main_control.
- Holds the PC and issues one-outstanding requests to instruction memory.
- Buffers the returned word and presents it to decode with a valid/ready handshake.
- id_opcode drives main_control.Opcode; redirects come from branch/jump resolution.

Parameters:
- XLEN, 32, width of PC and addresses.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- imem_req  output  1  fetch request, one cycle per request.
- imem_addr  output  XLEN  fetch address, valid when imem_req=1.
- imem_rvalid  input  1  response valid, at least 1 cycle after imem_req.
- imem_rdata  input  32  instruction word, valid with imem_rvalid.
- redirect_valid  input  1  taken branch/jump this cycle.
- redirect_pc  input  XLEN  redirect target.
- id_ready  input  1  decode accepts id_* this cycle.
- id_valid  output  1  id_* hold a valid instruction.
- id_instr  output  32  fetched instruction.
- id_pc  output  XLEN  address of id_instr.
- id_opcode  output  7  id_instr[6:0], to main_control.

Behaviour:
- Reset (reset==0 at clk edge) sets:
  - pc=RESET_PC, state=S_REQ, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0, hold buffer empty.
  - imem_req=0 while reset is asserted.
- Reset mid-operation: all state discarded; any outstanding imem response is dropped. imem shares the same reset.
- imem_req=(state==S_REQ); imem_addr=pc. One request outstanding at most. Memory always accepts.
- Transfer to decode occurs when id_valid && id_ready. A transfer with no new load clears id_valid next cycle.
- States:
  - S_REQ: issue request. Next S_WAIT; S_DRAIN if redirect_valid.
  - S_WAIT, on imem_rvalid with output slot free (!id_valid || id_ready):
    - id_instr<=imem_rdata, id_pc<=pc, id_valid<=1.
    - pc<=pc+4 (mod 2^XLEN, wraps).
    - Next S_REQ.
  - S_WAIT, on imem_rvalid with slot busy: capture rdata and pc into the hold buffer, pc<=pc+4, next S_FULL.
  - S_WAIT, no rvalid: stay.
  - S_FULL, on id_ready: id regs<=hold buffer, id_valid stays 1, next S_REQ.
  - S_DRAIN: wait for the stale response and discard it. Next S_REQ.
- Redirect has priority over every other event in the same cycle:
  - pc<=redirect_pc, id_valid<=0, hold buffer cleared.
  - From S_REQ or S_WAIT (response not yet returned): next S_DRAIN.
  - From S_WAIT with imem_rvalid the same cycle: discard rdata, next S_REQ.
  - From S_FULL: next S_REQ.
  - From S_DRAIN: update pc and stay in S_DRAIN; redirect_pc is overwritten by the latest redirect.
  - A coincident id_ready in that cycle is a legal transfer of the old id_* contents (decode's responsibility).
- imem_rvalid outside S_WAIT/S_DRAIN is ignored.
- Best throughput with 1-cycle memory: one instruction every 2 cycles.
- id_opcode is combinational from the id_instr register.

Optional Feature:
- Macro IF_MISALIGN_CHK_EN.
- When defined, adds output fetch_misalign (1 bit, reset 0).
- A redirect with redirect_pc[1:0]!=2'b00 does not change pc or state. It pulses fetch_misalign=1 for one cycle and still flushes id_valid.
- Without the macro: no port, and the target is used unmodified.

Decomposition:
- Shared include rv_defs.vh holds:
  - opcode constants: OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011, OP_JALR 1100111, OP_JAL 1101111, OP_IMM 0010011, OP_REG 0110011;
  - NOP_INSTR 32'h0000_0013;
  - fetch state encodings S_REQ/S_WAIT/S_FULL/S_DRAIN (2 bits).
- One natural sub-module: if_hold_buf (1-entry instr+pc buffer with load/clear/valid).

Test Plan:
- Reset release, 1-cycle memory returning 32'h00000513 at 0x0, id_ready=1:
  - imem_req at cycle 1 with addr 0x0.
  - id_valid=1, id_pc=0, id_opcode=7'b0010011 at cycle 3.
  - Next request addr 0x4.
- Back-pressure: id_ready=0 while the second word 32'h0000A083 returns:
  - state goes to S_FULL and no new imem_req;
  - raising id_ready gives id_instr=32'h0000A083, id_pc=0x4, then a request at 0x8.
- Redirect in S_WAIT to 0x100, stale response returned 2 cycles later:
  - stale word never appears on id_*;
  - next request addr 0x100; id_valid=0 until the 0x100 word returns.
- Redirect coincident with imem_rvalid (target 0x40): rdata dropped, next imem_req addr 0x40, id_valid=0.
- Reset asserted while in S_FULL: next cycle id_valid=0, id_instr=NOP, first request at RESET_PC after release.
- With IF_MISALIGN_CHK_EN, redirect_pc=0x102: fetch_misalign pulses 1 cycle, pc unchanged, id_valid=0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: RV32 major opcodes,
// the canonical NOP word and the fetch FSM state encoding.
package instr_fetch_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  // True for opcodes the downstream main_control decodes.
  function automatic logic is_known_opcode(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH) ||
           (op == OP_JALR) || (op == OP_JAL)   || (op == OP_IMM)    ||
           (op == OP_REG);
  endfunction

endpackage

// File: rtl/instr_fetch_hold_buf.sv
// if_hold_buf: one-entry instruction+PC skid buffer used when a fetch
// response arrives while the IF/ID register is still occupied.
module if_hold_buf
  import instr_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;

  // Occupancy flag; clear wins so a flush never leaves a stale entry behind.
  always_ff @(posedge clk) begin
    if (!reset)       r_valid <= 1'b0;
    else if (i_clear) r_valid <= 1'b0;
    else if (i_load)  r_valid <= 1'b1;
  end

  // Payload is captured on load only; the valid flag qualifies it.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, single-outstanding instruction-memory requester and the
// IF/ID register with a valid/ready handshake towards decode.
// Optional build macro IF_MISALIGN_CHK_EN adds the fetch_misalign output and
// rejects redirect targets that are not word aligned.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic            fetch_misalign
`endif
);

  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic            r_id_valid;
  logic [31:0]     r_id_instr;
  logic [XLEN-1:0] r_id_pc;

  logic            w_redir;       // redirect that moves pc / state
  logic            w_flush;       // any redirect: old id_* contents are dead
  logic            w_slot_free;
  logic            w_xfer;
  logic            w_id_load_mem;
  logic            w_id_load_hb;
  logic            w_hb_load;
  logic            w_hb_clear;
  logic            w_pc_inc;
  logic            w_hb_valid;
  logic [31:0]     w_hb_instr;
  logic [XLEN-1:0] w_hb_pc;

`ifdef IF_MISALIGN_CHK_EN
  logic            r_misalign;
  logic            w_misalign;
  assign w_misalign     = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_redir        = redirect_valid && !w_misalign;
  assign fetch_misalign = r_misalign;
`else
  assign w_redir = redirect_valid;
`endif
  assign w_flush     = redirect_valid;
  assign w_xfer      = r_id_valid && id_ready;
  assign w_slot_free = !r_id_valid || id_ready || w_flush;

  // Next-state logic; a redirect outranks every other event in the cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ:   w_state_nxt = w_redir ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (w_redir)          w_state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
        else if (imem_rvalid) w_state_nxt = w_slot_free ? S_REQ : S_FULL;
      end
      S_FULL:  if (w_redir || w_slot_free) w_state_nxt = S_REQ;
      // The stale response retires the drain even if a newer redirect lands
      // in the same cycle; waiting on would wait for a response never sent.
      S_DRAIN: if (imem_rvalid) w_state_nxt = S_REQ;
      default: w_state_nxt = S_REQ;
    endcase
  end

  // Output and datapath-enable decode from the current state.
  always_comb begin
    imem_req      = reset && (r_state == S_REQ);
    w_id_load_mem = (r_state == S_WAIT) && imem_rvalid && !w_redir && w_slot_free;
    w_hb_load     = (r_state == S_WAIT) && imem_rvalid && !w_redir && !w_slot_free;
    w_id_load_hb  = (r_state == S_FULL) && w_hb_valid && !w_redir && w_slot_free;
    w_pc_inc      = w_id_load_mem || w_hb_load;
    w_hb_clear    = w_redir || w_id_load_hb;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_REQ;
    else        r_state <= w_state_nxt;
  end

  // Program counter: redirect target, else advance once per captured word.
  always_ff @(posedge clk) begin
    if (!reset)        r_pc <= RESET_PC;
    else if (w_redir)  r_pc <= redirect_pc;
    else if (w_pc_inc) r_pc <= r_pc + XLEN'(4);
  end

  // IF/ID register: new word from memory or hold buffer, else drain on transfer/flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
      r_id_pc    <= '0;
    end else if (w_id_load_mem) begin
      r_id_valid <= 1'b1;
      r_id_instr <= imem_rdata;
      r_id_pc    <= r_pc;
    end else if (w_id_load_hb) begin
      r_id_valid <= 1'b1;
      r_id_instr <= w_hb_instr;
      r_id_pc    <= w_hb_pc;
    end else if (w_flush || w_xfer) begin
      r_id_valid <= 1'b0;
    end
  end

`ifdef IF_MISALIGN_CHK_EN
  // One-cycle pulse for each rejected (misaligned) redirect target.
  always_ff @(posedge clk) begin
    if (!reset) r_misalign <= 1'b0;
    else        r_misalign <= w_misalign;
  end
`endif

  if_hold_buf #(.XLEN(XLEN)) u_hold (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_hb_load),
    .i_clear (w_hb_clear),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .o_valid (w_hb_valid),
    .o_instr (w_hb_instr),
    .o_pc    (w_hb_pc)
  );

  assign imem_addr = r_pc;
  assign id_valid  = r_id_valid;
  assign id_instr  = r_id_instr;
  assign id_pc     = r_id_pc;
  assign id_opcode = r_id_instr[6:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized latency,
// back-pressure, redirects and resets. The reference model is the program-order
// stream of (pc, word) decode should see, restarted on each redirect or reset.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
`ifdef IF_MISALIGN_CHK_EN
  logic        fetch_misalign;
`endif

  instr_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_opcode      (id_opcode)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_xfer   = 0;
  exp_t        exp_q[$];
  logic [31:0] mpc;

  // stimulus configuration, written by the main sequence
  logic        cfg_rand    = 1'b0;
  int          cfg_lat     = 1;      // 0 = random 1..3
  logic        tb_ready    = 1'b1;
  logic        force_redir = 1'b0;
  logic [31:0] force_target = '0;

  // memory model state
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic        req_overlap = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0513;
    if (a == 32'h4) return 32'h0000_A083;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Driver: memory responder, decode back-pressure, redirects; model upkeep at each edge.
  initial begin : driver
    logic had;
    int   r;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    mpc            = RST_PC;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      req_overlap = 1'b0;
      had = pend;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend        = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (!had && cfg_rand && $urandom_range(0, 19) == 0) begin
        imem_rvalid = 1'b1;           // unsolicited response, must be ignored
        imem_rdata  = 32'hDEAD_BEEF;
      end
      if (reset && imem_req) begin
        if (pend) req_overlap = 1'b1;
        pend      = 1'b1;
        pend_cnt  = ((cfg_lat == 0) ? int'($urandom_range(1, 3)) : cfg_lat) - 1;
        pend_addr = imem_addr;
      end
      id_ready       = cfg_rand ? ($urandom_range(0, 9) < 7) : tb_ready;
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
      if (force_redir) begin
        redirect_valid = 1'b1;
        redirect_pc    = force_target;
        force_redir    = 1'b0;
      end else if (cfg_rand && $urandom_range(0, 99) < 4) begin
        redirect_valid = 1'b1;
        r = $urandom_range(0, 255);
        redirect_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : (32'(r) << 2);
      end
      @(posedge clk);
      if (!reset) begin
        exp_q.delete();
        mpc  = RST_PC;
        pend = 1'b0;
      end else if (redirect_valid) begin
        exp_q.delete();
        mpc = redirect_pc;
      end
      while (exp_q.size() < 4) begin
        exp_q.push_back('{pc: mpc, instr: mem_word(mpc)});
        mpc = mpc + 32'd4;
      end
    end
  end

  // Monitor: scoreboard pop on every decode transfer, plus request protocol checks.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        if (imem_req) chk("one_outstanding", 32'(req_overlap), 32'd0);
        if (id_valid && id_ready) begin
          n_xfer++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got pc %h with nothing expected", id_pc);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_pc", id_pc, e.pc);
            chk("xfer_instr", id_instr, e.instr);
            chk("xfer_opcode", 32'(id_opcode), 32'(e.instr[6:0]));
          end
        end
      end else begin
        chk("req_in_reset", 32'(imem_req), 32'd0);
      end
    end
  end

  initial begin : main
    int x0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    step();
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_opcode", 32'(id_opcode), 32'h13);
    @(posedge clk); #1; reset = 1'b1;
    step();                                            // cycle 1
    chk("c1_req", 32'(imem_req), 32'd1);
    chk("c1_addr", imem_addr, RST_PC);
    step(); tb_ready = 1'b0;                           // cycle 2
    step();                                            // cycle 3
    chk("c3_id_valid", 32'(id_valid), 32'd1);
    chk("c3_id_pc", id_pc, 32'h0);
    chk("c3_opcode", 32'(id_opcode), 32'h13);
    chk("c3_instr", id_instr, 32'h0000_0513);
    chk("c3_addr", imem_addr, 32'h4);
    step();                                            // cycle 4: word 2 returns
    step();                                            // cycle 5: held
    chk("full_no_req", 32'(imem_req), 32'd0);
    chk("full_id_instr", id_instr, 32'h0000_0513);
    tb_ready = 1'b1;
    step(); cfg_lat = 2;                               // cycle 6
    step();                                            // cycle 7
    chk("bp_id_instr", id_instr, 32'h0000_A083);
    chk("bp_id_pc", id_pc, 32'h4);
    chk("bp_req", 32'(imem_req), 32'd1);
    chk("bp_addr", imem_addr, 32'h8);
    force_target = 32'h100; force_redir = 1'b1;
    step();                                            // cycle 8: redirect in wait
    step();                                            // cycle 9: stale word
    chk("drain_id_valid", 32'(id_valid), 32'd0);
    step();                                            // cycle 10
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_id_valid", 32'(id_valid), 32'd0);
    cfg_lat = 1;
    step(); step();                                    // cycle 12
    chk("redir_wait_valid", 32'(id_valid), 32'd0);
    step();                                            // cycle 13
    chk("redir_word_valid", 32'(id_valid), 32'd1);
    chk("redir_word_pc", id_pc, 32'h100);
    force_target = 32'h40; force_redir = 1'b1;
    step();                                            // cycle 14: redirect + rvalid
    step();                                            // cycle 15
    chk("coin_req", 32'(imem_req), 32'd1);
    chk("coin_addr", imem_addr, 32'h40);
    chk("coin_id_valid", 32'(id_valid), 32'd0);
    tb_ready = 1'b0;
    step(); step();                                    // cycle 17
    chk("c17_id_pc", id_pc, 32'h40);
    step(); step();                                    // cycle 19: S_FULL
    chk("full2_no_req", 32'(imem_req), 32'd0);
    chk("full2_id_valid", 32'(id_valid), 32'd1);
    @(posedge clk); #1; reset = 1'b0;
    step();
    chk("rst_mid_req", 32'(imem_req), 32'd0);
    step();
    chk("rst_mid_id_valid", 32'(id_valid), 32'd0);
    chk("rst_mid_id_instr", id_instr, NOP);
    chk("rst_mid_id_pc", id_pc, 32'd0);
    @(posedge clk); #1; reset = 1'b1; tb_ready = 1'b1;
    step();
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, RST_PC);

    // randomized traffic with periodic resets
    cfg_rand = 1'b1;
    cfg_lat  = 0;
    for (int seg = 0; seg < 4; seg++) begin
      x0 = n_xfer;
      repeat (800) step();
      chk("progress", 32'(n_xfer > x0 + 50), 32'd1);
      @(posedge clk); #1; reset = 1'b0;
      repeat (2) @(posedge clk);
      #1; reset = 1'b1;
    end

    // steady stream: 1-cycle memory, decode always ready
    cfg_rand = 1'b0;
    cfg_lat  = 1;
    tb_ready = 1'b1;
    repeat (12) step();
    x0 = n_xfer;
    repeat (100) step();
    chk("throughput", 32'(n_xfer - x0), 32'd50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
